fc_layer_sequencer: RTL and testbench
=====================================

Name: fc_layer_sequencer

Overview:
- Requester side of the fully-connected weight/bias memory interface.
- For each output neuron, it fetches that neuron's bias and packed weight row from the weight/bias memory block, then runs a serial fixed-point multiply-accumulate against a latched input vector.
- Each finished neuron result is streamed out over a valid/ready handshake.
- Sits between the previous layer's output buffer and the next layer's input buffer in the dense-layer datapath.

Parameters:
- DATA_WIDTH, 16: signed fixed-point word width for inputs, weights, bias and result.
- FRAC_BITS, 8: fractional bits of the fixed-point format.
- INPUT_NODES, 120: inputs per neuron, i.e. weights per row.
- OUTPUT_NODES, 1200: neurons per layer.
- ADDR_WIDTH, 11: width of the neuron address; must satisfy 2^ADDR_WIDTH >= OUTPUT_NODES.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: begin a layer pass; accepted only in IDLE.
- in_vector, in, DATA_WIDTH*INPUT_NODES: input activations; element i is bits [i*DATA_WIDTH +: DATA_WIDTH]; latched on accepted start.
- weights_en, out, 1: weight row read request to memory.
- output_weights_addr, out, ADDR_WIDTH: neuron index of the weight row.
- weights_in, in, DATA_WIDTH*INPUT_NODES: weight row; valid the cycle after weights_en.
- bias_en, out, 1: bias read request.
- output_bias_addr, out, ADDR_WIDTH: neuron index of the bias.
- bias_in, in, DATA_WIDTH: bias word, connected to the low DATA_WIDTH bits of the memory's bias port; valid the cycle after bias_en.
- out_valid, out, 1: result available.
- out_ready, in, 1: downstream accepts.
- out_data, out, DATA_WIDTH: neuron result.
- out_index, out, ADDR_WIDTH: neuron index of out_data.
- busy, out, 1: high whenever the state is not IDLE.
- layer_done, out, 1: one-cycle pulse after the last neuron is accepted.

Behaviour:
- Reset (synchronous, rst=1): all outputs 0, state IDLE, neuron counter 0, accumulator 0, latched vector 0. Reset mid-pass aborts immediately; no further requests are issued.
- weights_en and bias_en are never high in the same cycle, because the memory prioritises weights. Each is a single-cycle pulse.
- IDLE: on start=1, latch in_vector, set n=0, go to REQ_B. start is ignored in every other state.
- REQ_B: bias_en=1, output_bias_addr=n. Next state WAIT_B.
- WAIT_B: capture bias_in. Next state REQ_W.
- REQ_W: weights_en=1, output_weights_addr=n. Next state WAIT_W.
- WAIT_W: capture weights_in into a row register, clear the accumulator, set k=0. Next state MAC.
- MAC: each cycle, acc += sign-extended in[k]*w[k] as a full 2*DATA_WIDTH product. k increments; after k=INPUT_NODES-1 go to FIN. Accumulator width is 2*DATA_WIDTH+clog2(INPUT_NODES) and never overflows.
- FIN: result = (acc >>> FRAC_BITS) + sign-extended bias, computed at accumulator width. Saturate to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Rounding is truncation toward negative infinity. Register out_data and out_index=n, set out_valid=1, go to OUT.
- OUT: out_data and out_index hold stable while out_valid && !out_ready. On out_valid && out_ready:
  - clear out_valid;
  - if n==OUTPUT_NODES-1, pulse layer_done next cycle and go to IDLE;
  - otherwise n++ and go to REQ_B.
- Throughput with out_ready held high: INPUT_NODES+6 cycles per neuron (REQ_B, WAIT_B, REQ_W, WAIT_W, MAC×N, FIN, OUT).
- Address outputs hold their last value when their enable is low.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: FC_SEQ_RELU_EN.
- Defined: in FIN, any saturated result below 0 becomes 0, i.e. ReLU is applied after saturation.
- Undefined: signed saturated results pass through unchanged.
- Cycle timing is identical in both builds.

Test Plan:
- Params INPUT_NODES=4, OUTPUT_NODES=3. Weights all 0x0100, in_vector={0x0100,0x0200,0x0300,0x0400}, bias 0x0080 -> each neuron out_data=0x0A80; out_index 0,1,2; layer_done one cycle after the third handshake; 10 cycles per neuron with out_ready=1.
- Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFF -> out_data=0x7FFF (saturated high). Weights 0x8000, inputs 0x7FFF -> out_data=0x8000 (saturated low).
- Weights 0xFF00 (-1.0), inputs 0x0100, bias 0 -> out_data=0xFC00 with macro undefined; out_data=0x0000 with FC_SEQ_RELU_EN.
- Hold out_ready=0 for 5 cycles at neuron 1 -> out_valid, out_data and out_index stay stable, no bias_en/weights_en pulses occur, and fetching of neuron 2 starts only after the handshake.
- Pulse rst during MAC of neuron 1 -> next cycle all outputs 0 and state IDLE. A new start restarts at n=0 and produces correct results.
- Hold start high throughout the pass -> no re-latch mid-pass. Monitor checks weights_en and bias_en are never both high and that addresses match n.

Source files
------------

// File: rtl/fc_layer_sequencer.sv
// Dense-layer sequencer: fetches bias and weight row per neuron, runs a serial MAC, streams results.
// Optional build macro FC_SEQ_RELU_EN clamps negative saturated results to zero.
module fc_layer_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int INPUT_NODES  = 120,
  parameter int OUTPUT_NODES = 1200,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0] in_vector,
  output logic                              weights_en,
  output logic [ADDR_WIDTH-1:0]             output_weights_addr,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0] weights_in,
  output logic                              bias_en,
  output logic [ADDR_WIDTH-1:0]             output_bias_addr,
  input  logic [DATA_WIDTH-1:0]             bias_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [ADDR_WIDTH-1:0]             out_index,
  output logic                              busy,
  output logic                              layer_done
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(INPUT_NODES);
  localparam int K_W   = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1;
  localparam logic [K_W-1:0]        K_LAST = K_W'(INPUT_NODES-1);
  localparam logic [ADDR_WIDTH-1:0] N_LAST = ADDR_WIDTH'(OUTPUT_NODES-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, REQ_B, WAIT_B, REQ_W, WAIT_W, MAC, FIN, OUT} state_t;

  state_t                             state;
  logic [DATA_WIDTH*INPUT_NODES-1:0]  vec_q;
  logic [DATA_WIDTH*INPUT_NODES-1:0]  row_q;
  logic [DATA_WIDTH-1:0]              bias_q;
  logic signed [ACC_W-1:0]            acc;
  logic [K_W-1:0]                     k;
  logic [ADDR_WIDTH-1:0]              n;

  logic signed [2*DATA_WIDTH-1:0]     prod;
  logic signed [ACC_W-1:0]            prod_ext;
  logic signed [ACC_W-1:0]            sum;
  logic [DATA_WIDTH-1:0]              result;

  always_comb begin
    prod     = $signed(vec_q[k*DATA_WIDTH +: DATA_WIDTH]) *
               $signed(row_q[k*DATA_WIDTH +: DATA_WIDTH]);
    prod_ext = $signed({{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod});
    // Arithmetic shift floors toward negative infinity before the bias is added.
    sum      = (acc >>> FRAC_BITS) +
               $signed({{(ACC_W-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q});
    if (sum > SAT_MAX)
      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (sum < SAT_MIN)
      result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      result = sum[DATA_WIDTH-1:0];
`ifdef FC_SEQ_RELU_EN
    if (result[DATA_WIDTH-1])
      result = '0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      vec_q               <= '0;
      row_q               <= '0;
      bias_q              <= '0;
      acc                 <= '0;
      k                   <= '0;
      n                   <= '0;
      weights_en          <= 1'b0;
      output_weights_addr <= '0;
      bias_en             <= 1'b0;
      output_bias_addr    <= '0;
      out_valid           <= 1'b0;
      out_data            <= '0;
      out_index           <= '0;
      busy                <= 1'b0;
      layer_done          <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          vec_q            <= in_vector;
          n                <= '0;
          bias_en          <= 1'b1;
          output_bias_addr <= '0;
          busy             <= 1'b1;
          state            <= REQ_B;
        end
        REQ_B: begin
          bias_en <= 1'b0;
          state   <= WAIT_B;
        end
        WAIT_B: begin
          bias_q              <= bias_in;
          weights_en          <= 1'b1;
          output_weights_addr <= n;
          state               <= REQ_W;
        end
        REQ_W: begin
          weights_en <= 1'b0;
          state      <= WAIT_W;
        end
        WAIT_W: begin
          row_q <= weights_in;
          acc   <= '0;
          k     <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 1'b1;
          if (k == K_LAST)
            state <= FIN;
        end
        FIN: begin
          out_data  <= result;
          out_index <= n;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (n == N_LAST) begin
            layer_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            n                <= n + 1'b1;
            bias_en          <= 1'b1;
            output_bias_addr <= n + 1'b1;
            state            <= REQ_B;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with a small registered weight/bias memory model.
module tb_fc_layer_sequencer;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int IN = 4;
  localparam int ON = 3;
  localparam int AW = 2;
`ifdef FC_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, out_ready;
  logic [DW*IN-1:0]   in_vector, weights_in;
  logic [DW-1:0]      bias_in;
  logic               weights_en, bias_en, out_valid, busy, layer_done;
  logic [AW-1:0]      output_weights_addr, output_bias_addr, out_index;
  logic [DW-1:0]      out_data;

  logic [DW*IN-1:0]   mem_row;
  logic [DW-1:0]      mem_bias;
  int errors = 0;
  int checks = 0;
  int mon_n  = 0;
  int cnt;

  fc_layer_sequencer #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .INPUT_NODES(IN),
    .OUTPUT_NODES(ON), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_vector(in_vector),
    .weights_en(weights_en), .output_weights_addr(output_weights_addr),
    .weights_in(weights_in), .bias_en(bias_en), .output_bias_addr(output_bias_addr),
    .bias_in(bias_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .busy(busy), .layer_done(layer_done)
  );

  // Memory returns data one cycle after the request; otherwise unknown.
  always @(posedge clk) begin
    bias_in    <= bias_en    ? mem_bias : 'x;
    weights_in <= weights_en ? mem_row  : 'x;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference neuron index, advanced on each handshake.
  always @(posedge clk) begin
    if (rst) mon_n <= 0;
    else if (out_valid && out_ready) mon_n <= (mon_n == ON-1) ? 0 : mon_n + 1;
  end

  always @(negedge clk) begin
    if (bias_en || weights_en) begin
      chk("en_exclusive", {31'b0, bias_en & weights_en}, 32'd0);
      if (bias_en) chk("bias_addr", {30'b0, output_bias_addr}, mon_n);
      else         chk("weights_addr", {30'b0, output_weights_addr}, mon_n);
    end
  end

  task automatic set_in(input logic [DW-1:0] a0, a1, a2, a3);
    in_vector = {a3, a2, a1, a0};
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < 40);
  endtask

  task automatic run_pass(input string tag, input logic [DW-1:0] exp, input bit hold_start);
    int c;
    start = 1'b1;
    @(negedge clk);
    start = hold_start;
    if (hold_start) set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int j = 0; j < ON; j++) begin
      wait_valid(c);
      chk({tag, "_valid"},  {31'b0, out_valid}, 32'd1);
      chk({tag, "_cycles"}, c, (j == 0) ? 32'd9 : 32'd10);
      chk({tag, "_data"},   {16'b0, out_data}, {16'b0, exp});
      chk({tag, "_index"},  {30'b0, out_index}, j);
      chk({tag, "_busy"},   {30'b0, busy, layer_done}, 32'd2);
      if (j == ON-1) start = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done"}, {30'b0, layer_done, busy}, 32'd2);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, layer_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    in_vector = '0; mem_row = '0; mem_bias = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {9'b0, busy, out_valid, layer_done, bias_en, weights_en, out_data, out_index}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0*(1+2+3+4) + 0.5 = 10.5 -> 0x0A80
    set_in(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    mem_row = {IN{16'h0100}}; mem_bias = 16'h0080;
    run_pass("basic", 16'h0A80, 1'b0);

    set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    mem_row = {IN{16'h7FFF}}; mem_bias = 16'h7FFF;
    run_pass("sat_hi", 16'h7FFF, 1'b0);

    mem_row = {IN{16'h8000}}; mem_bias = 16'h0000;
    run_pass("sat_lo", RELU ? 16'h0000 : 16'h8000, 1'b0);

    set_in(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    mem_row = {IN{16'hFF00}};
    run_pass("neg", RELU ? 16'h0000 : 16'hFC00, 1'b0);

    // Sum of products is -4 LSB^2; flooring the shift gives -1 LSB.
    set_in(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    mem_row = {IN{16'hFFFF}};
    run_pass("floor", RELU ? 16'h0000 : 16'hFFFF, 1'b0);

    // Backpressure on neuron 1.
    set_in(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    mem_row = {IN{16'h0100}}; mem_bias = 16'h0080;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cnt);
    chk("stall_n0_data", {16'b0, out_data}, 32'h0A80);
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid(cnt);
    chk("stall_n1_cycles", cnt, 32'd9);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", {13'b0, out_valid, bias_en, weights_en, out_index, out_data},
          {13'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0A80});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", {29'b0, out_valid, bias_en, output_bias_addr}, {29'b0, 1'b0, 1'b1, 2'd2});
    wait_valid(cnt);
    chk("stall_n2_index", {30'b0, out_index}, 32'd2);
    @(negedge clk);
    chk("stall_done", {31'b0, layer_done}, 32'd1);
    @(negedge clk);

    // Reset during MAC of neuron 1.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cnt);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs",
        {5'b0, busy, out_valid, layer_done, bias_en, weights_en, out_data, out_index,
         output_bias_addr, output_weights_addr}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", {29'b0, busy, bias_en, weights_en}, 32'd0);
    end
    run_pass("restart", 16'h0A80, 1'b0);

    // start held high and in_vector changed mid-pass must not re-latch.
    set_in(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    run_pass("hold_start", 16'h0A80, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
